// File: rtl/qrd_input_sequencer.sv
// Input sequencer for the 4-tap QRD-RLS array: buffers {x, d} samples, builds the
// x(n)..x(n-3) tap line and emits one update strobe per sample, spaced ISSUE_GAP cycles.
module qrd_input_sequencer #(
  parameter int DATA_LENGTH = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int ISSUE_GAP   = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DATA_LENGTH-1:0]        s_x,
  input  logic [DATA_LENGTH-1:0]        s_d,
  output logic [DATA_LENGTH-1:0]        input_to_BC1,
  output logic [DATA_LENGTH-1:0]        input_to_IC1,
  output logic [DATA_LENGTH-1:0]        input_to_IC2,
  output logic [DATA_LENGTH-1:0]        input_to_IC3,
  output logic [DATA_LENGTH-1:0]        input_signal_sk,
  output logic                          ready_in_sig,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   issue_count,
  output logic                          state_dbg
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(ISSUE_GAP + 1);
  localparam int DW = 2 * DATA_LENGTH;

  typedef enum logic {IDLE = 1'b0, GAP = 1'b1} state_t;

  state_t             state;
  logic [CW-1:0]      gap_cnt;
  logic [DW-1:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [DW-1:0]      head;
  logic               full;
  logic               empty;
  logic               push;
  logic               issue;

  // Handshake: a sample transfers on a rising edge where s_valid and s_ready are both
  // high; s_ready depends only on the registered level, clear and reset, never on s_valid.
  assign full    = (fifo_level == (AW + 1)'(FIFO_DEPTH));
  assign empty   = (fifo_level == '0);
  assign s_ready = rst && !full && !clear;
  assign push    = s_valid && s_ready;
  assign head    = mem[rd_ptr];

  // Issue when idle, or exactly when the spacing window closes; clear always suppresses it.
  assign issue   = !clear && !empty &&
                   ((state == IDLE) || ((state == GAP) && (gap_cnt == CW'(1))));

  assign state_dbg = (state == GAP);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {s_x, s_d};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else if (clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (issue) rd_ptr <= rd_ptr + AW'(1);
      case ({push, issue})
        2'b10:   fifo_level <= fifo_level + (AW + 1)'(1);
        2'b01:   fifo_level <= fifo_level - (AW + 1)'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      gap_cnt         <= '0;
      ready_in_sig    <= 1'b0;
      issue_count     <= '0;
      input_to_BC1    <= '0;
      input_to_IC1    <= '0;
      input_to_IC2    <= '0;
      input_to_IC3    <= '0;
      input_signal_sk <= '0;
    end else begin
      ready_in_sig <= 1'b0;
      if (clear) begin
        input_to_BC1    <= '0;
        input_to_IC1    <= '0;
        input_to_IC2    <= '0;
        input_to_IC3    <= '0;
        input_signal_sk <= '0;
      end else if (issue) begin
        input_to_IC3    <= input_to_IC2;
        input_to_IC2    <= input_to_IC1;
        input_to_IC1    <= input_to_BC1;
        input_to_BC1    <= head[DW-1:DATA_LENGTH];
        input_signal_sk <= head[DATA_LENGTH-1:0];
        ready_in_sig    <= 1'b1;
        issue_count     <= issue_count + 16'd1;
      end

      // The spacing counter runs regardless of clear so strobes never come too close.
      case (state)
        IDLE: begin
          if (issue) begin
            state   <= GAP;
            gap_cnt <= CW'(ISSUE_GAP);
          end
        end
        GAP: begin
          if (gap_cnt == CW'(1)) begin
            if (issue) begin
              gap_cnt <= CW'(ISSUE_GAP);
            end else begin
              state   <= IDLE;
              gap_cnt <= '0;
            end
          end else begin
            gap_cnt <= gap_cnt - CW'(1);
          end
        end
        default: begin
          state   <= IDLE;
          gap_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qrd_input_sequencer.sv
// Bench for qrd_input_sequencer: directed table, corner-case sequences and random
// traffic checked against a queue-based model of sample flow and issue spacing.
module tb_qrd_input_sequencer;

  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int GAP   = 32;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          clear;
  logic          s_valid;
  logic          s_ready;
  logic [W-1:0]  s_x;
  logic [W-1:0]  s_d;
  logic [W-1:0]  input_to_BC1;
  logic [W-1:0]  input_to_IC1;
  logic [W-1:0]  input_to_IC2;
  logic [W-1:0]  input_to_IC3;
  logic [W-1:0]  input_signal_sk;
  logic          ready_in_sig;
  logic [LW-1:0] fifo_level;
  logic [15:0]   issue_count;
  logic          state_dbg;

  always #5 clk = ~clk;

  qrd_input_sequencer #(.DATA_LENGTH(W), .FIFO_DEPTH(DEPTH), .ISSUE_GAP(GAP)) dut (
    .clk(clk), .rst(rst), .clear(clear), .s_valid(s_valid), .s_ready(s_ready),
    .s_x(s_x), .s_d(s_d),
    .input_to_BC1(input_to_BC1), .input_to_IC1(input_to_IC1),
    .input_to_IC2(input_to_IC2), .input_to_IC3(input_to_IC3),
    .input_signal_sk(input_signal_sk), .ready_in_sig(ready_in_sig),
    .fifo_level(fifo_level), .issue_count(issue_count), .state_dbg(state_dbg)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: pending samples, tap history, last issue edge.
  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]   m_tap[4];
  logic [W-1:0]   m_sk;
  logic           m_strobe;
  logic [15:0]    m_cnt;
  longint         m_last;
  longint         ec;
  bit             m_acc;
  bit             prev_strobe;
  longint         strobe_log[$];

  typedef struct {
    bit       c;
    bit       v;
    logic [W-1:0] x;
    logic [W-1:0] d;
    bit       e_str;
    logic [W-1:0] e_bc1;
    logic [W-1:0] e_ic1;
    logic [W-1:0] e_sk;
    int       e_lvl;
    int       e_cnt;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h edge=%0d", nm, act, req, ec);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < 4; i++) m_tap[i] = '0;
    m_sk     = '0;
    m_strobe = 1'b0;
    m_cnt    = '0;
    m_last   = -1000000;
  endtask

  task automatic compare_model();
    chk("bc1",   32'(input_to_BC1),    32'(m_tap[0]));
    chk("ic1",   32'(input_to_IC1),    32'(m_tap[1]));
    chk("ic2",   32'(input_to_IC2),    32'(m_tap[2]));
    chk("ic3",   32'(input_to_IC3),    32'(m_tap[3]));
    chk("sk",    32'(input_signal_sk), 32'(m_sk));
    chk("strobe", 32'(ready_in_sig),   32'(m_strobe));
    chk("level", 32'(fifo_level),      32'(exp_q.size()));
    chk("count", 32'(issue_count),     32'(m_cnt));
    chk("strobe_spacing", 32'(ready_in_sig && prev_strobe), 32'd0);
  endtask

  // One clock: drive at negedge, advance the model across the coming edge, check at next negedge.
  task automatic step(input bit r, input bit c, input bit v, input logic [W-1:0] x,
                      input logic [W-1:0] d);
    bit             exp_rdy;
    bit             can_issue;
    logic [2*W-1:0] h;
    rst = r; clear = c; s_valid = v; s_x = x; s_d = d;
    #1;
    exp_rdy = r && !c && (exp_q.size() < DEPTH);
    chk("s_ready", 32'(s_ready), 32'(exp_rdy));
    m_acc = v && exp_rdy;
    if (!r) begin
      model_reset();
    end else begin
      can_issue = !c && (exp_q.size() > 0) && (ec - m_last >= GAP);
      m_strobe  = 1'b0;
      if (c) begin
        exp_q.delete();
        for (int i = 0; i < 4; i++) m_tap[i] = '0;
        m_sk = '0;
      end
      if (can_issue) begin
        h        = exp_q.pop_front();
        m_tap[3] = m_tap[2];
        m_tap[2] = m_tap[1];
        m_tap[1] = m_tap[0];
        m_tap[0] = h[2*W-1:W];
        m_sk     = h[W-1:0];
        m_strobe = 1'b1;
        m_cnt    = m_cnt + 16'd1;
        m_last   = ec;
      end
      if (m_acc) exp_q.push_back({x, d});
    end
    @(negedge clk);
    compare_model();
    chk("state", 32'(state_dbg), 32'(r && (ec - m_last < GAP)));
    prev_strobe = ready_in_sig;
    if (ready_in_sig) strobe_log.push_back(ec);
    ec++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    longint p;
    longint cnt_before;
    int     n;
    int     guard;
    bit     saw_full;
    int     rate;

    rst = 1'b0; clear = 1'b0; s_valid = 1'b0; s_x = '0; s_d = '0;
    ec = 0; prev_strobe = 1'b0;
    model_reset();
    @(negedge clk);

    // Reset values and the single-sample / clear table.
    do_reset();
    tbl[0] = '{1'b0, 1'b1, 8'h10, 8'h20, 1'b0, 8'h00, 8'h00, 8'h00, 1, 0};
    tbl[1] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h10, 8'h00, 8'h20, 0, 1};
    tbl[2] = '{1'b0, 1'b1, 8'h30, 8'h40, 1'b0, 8'h10, 8'h00, 8'h20, 1, 1};
    tbl[3] = '{1'b0, 1'b1, 8'h50, 8'h60, 1'b0, 8'h10, 8'h00, 8'h20, 2, 1};
    tbl[4] = '{1'b1, 1'b1, 8'h77, 8'h77, 1'b0, 8'h00, 8'h00, 8'h00, 0, 1};
    tbl[5] = '{1'b0, 1'b1, 8'h11, 8'h22, 1'b0, 8'h00, 8'h00, 8'h00, 1, 1};
    strobe_log.delete();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, tbl[i].c, tbl[i].v, tbl[i].x, tbl[i].d);
      chk("tbl_strobe", 32'(ready_in_sig),    32'(tbl[i].e_str));
      chk("tbl_bc1",    32'(input_to_BC1),    32'(tbl[i].e_bc1));
      chk("tbl_ic1",    32'(input_to_IC1),    32'(tbl[i].e_ic1));
      chk("tbl_sk",     32'(input_signal_sk), 32'(tbl[i].e_sk));
      chk("tbl_level",  32'(fifo_level),      32'(tbl[i].e_lvl));
      chk("tbl_count",  32'(issue_count),     32'(tbl[i].e_cnt));
    end
    idle(40);
    chk("tbl_nstrobes", 32'(strobe_log.size()), 32'd2);
    if (strobe_log.size() == 2) chk("tbl_gap", 32'(strobe_log[1] - strobe_log[0]), 32'(GAP));
    chk("tbl_bc1_after", 32'(input_to_BC1),    32'h11);
    chk("tbl_ic1_after", 32'(input_to_IC1),    32'h00);
    chk("tbl_sk_after",  32'(input_signal_sk), 32'h22);

    // Burst of six samples into a four-deep FIFO.
    do_reset();
    strobe_log.delete();
    n = 1; guard = 0; saw_full = 1'b0;
    while (n <= 6 && guard < 400) begin
      step(1'b1, 1'b0, 1'b1, 8'(n), 8'(n + 100));
      if (m_acc) n++;
      if (!s_ready && fifo_level == LW'(DEPTH)) saw_full = 1'b1;
      guard++;
    end
    chk("burst_accept_timeout", 32'(n), 32'd7);
    chk("burst_full_seen", 32'(saw_full), 32'd1);
    idle(200);
    chk("burst_nstrobes", 32'(strobe_log.size()), 32'd6);
    for (int i = 1; i < strobe_log.size(); i++)
      chk("burst_spacing", 32'(strobe_log[i] - strobe_log[i-1]), 32'(GAP));
    chk("burst_bc1", 32'(input_to_BC1), 32'd6);
    chk("burst_ic1", 32'(input_to_IC1), 32'd5);
    chk("burst_ic2", 32'(input_to_IC2), 32'd4);
    chk("burst_ic3", 32'(input_to_IC3), 32'd3);
    chk("burst_count", 32'(issue_count), 32'd6);

    // Late arrival: second sample after the gap has expired issues on the next edge.
    strobe_log.delete();
    step(1'b1, 1'b0, 1'b1, 8'h21, 8'h31);
    idle(50);
    p = ec;
    step(1'b1, 1'b0, 1'b1, 8'h22, 8'h32);
    chk("late_accept", 32'(m_acc), 32'd1);
    idle(1);
    chk("late_nstrobes", 32'(strobe_log.size()), 32'd2);
    if (strobe_log.size() == 2) chk("late_latency", 32'(strobe_log[1] - p), 32'd1);

    // Clear landing exactly where the spacing counter expires with two entries queued.
    idle(40);
    p = ec;
    step(1'b1, 1'b0, 1'b1, 8'h41, 8'h51);
    idle(1);
    step(1'b1, 1'b0, 1'b1, 8'h42, 8'h52);
    step(1'b1, 1'b0, 1'b1, 8'h43, 8'h53);
    while (ec < p + 1 + GAP) idle(1);
    chk("clr_pre_level", 32'(fifo_level), 32'd2);
    cnt_before = longint'(m_cnt);
    step(1'b1, 1'b1, 1'b0, '0, '0);
    chk("clr_strobe", 32'(ready_in_sig), 32'd0);
    chk("clr_level",  32'(fifo_level),   32'd0);
    chk("clr_bc1",    32'(input_to_BC1), 32'd0);
    chk("clr_count",  32'(issue_count),  32'(cnt_before));
    chk("clr_state",  32'(state_dbg),    32'd0);

    // Asynchronous reset in the middle of a gap with three samples queued.
    step(1'b1, 1'b0, 1'b1, 8'h51, 8'h61);
    step(1'b1, 1'b0, 1'b1, 8'h52, 8'h62);
    step(1'b1, 1'b0, 1'b1, 8'h53, 8'h63);
    step(1'b1, 1'b0, 1'b1, 8'h54, 8'h64);
    idle(3);
    chk("rst_pre_level", 32'(fifo_level), 32'd3);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_bc1",    32'(input_to_BC1),    32'd0);
    chk("rst_ic1",    32'(input_to_IC1),    32'd0);
    chk("rst_sk",     32'(input_signal_sk), 32'd0);
    chk("rst_level",  32'(fifo_level),      32'd0);
    chk("rst_count",  32'(issue_count),     32'd0);
    chk("rst_sready", 32'(s_ready),         32'd0);
    chk("rst_state",  32'(state_dbg),       32'd0);
    @(negedge clk);
    model_reset();
    prev_strobe = 1'b0;
    ec++;
    step(1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b0, 1'b1, 8'h71, 8'h72);
    idle(1);
    chk("rst_resume_strobe", 32'(ready_in_sig),    32'd1);
    chk("rst_resume_bc1",    32'(input_to_BC1),    32'h71);
    chk("rst_resume_ic1",    32'(input_to_IC1),    32'd0);
    chk("rst_resume_ic2",    32'(input_to_IC2),    32'd0);
    chk("rst_resume_ic3",    32'(input_to_IC3),    32'd0);
    chk("rst_resume_sk",     32'(input_signal_sk), 32'h72);

    // Random traffic with varying offered load and occasional clear.
    for (int blk = 0; blk < 15; blk++) begin
      rate = int'($urandom_range(2, 90));
      for (int i = 0; i < 200; i++) begin
        step(1'b1, ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < rate),
             8'($urandom), 8'($urandom));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
